// File: rtl/ifetch_pkg.sv
// Shared encodings and queue-entry layout for the ifetch_pq instruction-fetch unit.
package ifetch_pkg;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_IMM = 2'b01;
   localparam logic [1:0] PC_ALU = 2'b10;
   localparam logic [1:0] PC_RST = 2'b11;

   localparam int unsigned DEF_ADDR_WIDTH = 11;
   localparam int unsigned DEF_DATA_WIDTH = 32;

   // Queue entry at the default geometry; the FIFO stores {pc, instr} in this order.
   typedef struct packed {
      logic [DEF_ADDR_WIDTH-1:0] pc;
      logic [DEF_DATA_WIDTH-1:0] instr;
   } pq_entry_t;

endpackage

// File: rtl/ifetch_dpram.sv
// Dual-port ICCM: port A synchronous write, port B registered read, both on clk_i.
module ifetch_dpram #(
   parameter int AW = 11,
   parameter int DW = 32
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          a_we_i,
   input  logic [AW-1:0] a_addr_i,
   input  logic [DW-1:0] a_data_i,
   input  logic          b_re_i,
   input  logic [AW-1:0] b_addr_i,
   output logic [DW-1:0] b_data_o
);

   logic [DW-1:0] mem_q [0:(1<<AW)-1];
   logic [DW-1:0] b_data_q;

   always_ff @(posedge clk_i) begin
      if (a_we_i) mem_q[a_addr_i] <= a_data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)     b_data_q <= '0;
      else if (b_re_i) b_data_q <= mem_q[b_addr_i];
   end

   assign b_data_o = b_data_q;

endmodule

// File: rtl/ifetch_pfq.sv
// Prefetch FIFO: DEPTH entries of WIDTH bits with push, pop, flush and an occupancy count.
module ifetch_pfq #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 43,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic [CW-1:0]    count_o
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   // Flush wins over a same-cycle push or pop.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/ifetch_pq.sv
// Instruction fetch with prefetch queue. Define IFETCH_CNTLR_RD_EN to add the controller read port.
module ifetch_pq
   import ifetch_pkg::*;
#(
   parameter int          ADDR_WIDTH = 11,
   parameter int          DATA_WIDTH = 32,
   parameter int          PF_DEPTH   = 4,
   parameter int unsigned RESET_PC   = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fetch_en,
   input  logic [1:0]            pc_sel,
   input  logic [ADDR_WIDTH-1:0] imm_addr,
   input  logic [ADDR_WIDTH-1:0] alu_addr,
   output logic                  if_valid,
   input  logic                  if_ready,
   output logic [DATA_WIDTH-1:0] if_instr,
   output logic [ADDR_WIDTH-1:0] if_pc,
   input  logic                  cntlr_wr,
   input  logic [ADDR_WIDTH-1:0] cntlr_waddr,
   input  logic [DATA_WIDTH-1:0] cntlr_wr_data
`ifdef IFETCH_CNTLR_RD_EN
   ,
   input  logic                  cntlr_rd,
   input  logic [ADDR_WIDTH-1:0] cntlr_raddr,
   output logic [DATA_WIDTH-1:0] cntlr_rd_data,
   output logic                  cntlr_rd_valid
`endif
);

   localparam int CW = $clog2(PF_DEPTH) + 1;
   localparam int EW = ADDR_WIDTH + DATA_WIDTH;

   logic [ADDR_WIDTH-1:0] fpc_q, fpc_d, fetch_pc_q, fetch_pc_d;
   logic                  inflight_q, inflight_d, kill_q, kill_d;
   logic [CW-1:0]         count, occ;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [EW-1:0]         head;
   logic                  pop, push, flush, issue, rd_req;

`ifdef IFETCH_CNTLR_RD_EN
   logic rd_valid_q;

   assign rd_req         = cntlr_rd;
   assign rd_addr        = cntlr_rd ? cntlr_raddr : fpc_q;
   assign cntlr_rd_data  = rd_data;
   assign cntlr_rd_valid = rd_valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_valid_q <= 1'b0;
      else        rd_valid_q <= cntlr_rd;
   end
`else
   assign rd_req  = 1'b0;
   assign rd_addr = fpc_q;
`endif

   // Decode handshake: a word transfers on a cycle with if_valid & if_ready; while
   // if_valid is high and if_ready low, if_pc/if_instr hold; a flush voids that cycle's transfer.
   assign pop   = if_valid & if_ready;
   assign flush = (pc_sel != PC_SEQ) | cntlr_wr;
   assign occ   = count + CW'(inflight_q) - CW'(pop);
   assign issue = fetch_en & ~flush & ~rd_req & (occ < CW'(PF_DEPTH));
   assign push  = inflight_q & ~kill_q & ~flush;

   always_comb begin
      fpc_d      = fpc_q;
      fetch_pc_d = fetch_pc_q;
      if (issue) begin
         fpc_d      = fpc_q + ADDR_WIDTH'(1);
         fetch_pc_d = fpc_q;
      end
      case (pc_sel)
         PC_IMM:  fpc_d = imm_addr;
         PC_ALU:  fpc_d = alu_addr;
         PC_RST:  fpc_d = ADDR_WIDTH'(RESET_PC);
         default: ;
      endcase
      inflight_d = issue;
      // A read outstanding across a flush must never reach the queue.
      kill_d     = flush & inflight_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fpc_q      <= ADDR_WIDTH'(RESET_PC);
         fetch_pc_q <= '0;
         inflight_q <= 1'b0;
         kill_q     <= 1'b0;
      end else begin
         fpc_q      <= fpc_d;
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= inflight_d;
         kill_q     <= kill_d;
      end
   end

   ifetch_dpram #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_iccm (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .a_we_i   (cntlr_wr),
      .a_addr_i (cntlr_waddr),
      .a_data_i (cntlr_wr_data),
      .b_re_i   (issue | rd_req),
      .b_addr_i (rd_addr),
      .b_data_o (rd_data)
   );

   ifetch_pfq #(.DEPTH(PF_DEPTH), .WIDTH(EW), .CW(CW)) u_pfq (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (flush),
      .data_i  ({fetch_pc_q, rd_data}),
      .data_o  (head),
      .count_o (count)
   );

   assign if_valid = (count != '0);
   assign if_pc    = head[EW-1:DATA_WIDTH];
   assign if_instr = head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_ifetch_pq.sv
// Bench for ifetch_pq: queue-level reference model plus directed and random scenarios.
module tb_ifetch_pq;
   import ifetch_pkg::*;

   localparam int AW  = 11;
   localparam int DW  = 32;
   localparam int PFD = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          fetch_en = 1'b0;
   logic [1:0]    pc_sel = PC_SEQ;
   logic [AW-1:0] imm_addr = '0;
   logic [AW-1:0] alu_addr = '0;
   logic          if_ready = 1'b0;
   logic          cntlr_wr = 1'b0;
   logic [AW-1:0] cntlr_waddr = '0;
   logic [DW-1:0] cntlr_wr_data = '0;
   logic          cntlr_rd = 1'b0;
   logic [AW-1:0] cntlr_raddr = '0;
   logic          if_valid;
   logic [DW-1:0] if_instr;
   logic [AW-1:0] if_pc;
`ifdef IFETCH_CNTLR_RD_EN
   logic [DW-1:0] cntlr_rd_data;
   logic          cntlr_rd_valid;
`endif

   always #5 clk = ~clk;

   ifetch_pq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PF_DEPTH(PFD), .RESET_PC(0)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .pc_sel(pc_sel),
      .imm_addr(imm_addr), .alu_addr(alu_addr), .if_valid(if_valid), .if_ready(if_ready),
      .if_instr(if_instr), .if_pc(if_pc), .cntlr_wr(cntlr_wr), .cntlr_waddr(cntlr_waddr),
      .cntlr_wr_data(cntlr_wr_data)
`ifdef IFETCH_CNTLR_RD_EN
      , .cntlr_rd(cntlr_rd), .cntlr_raddr(cntlr_raddr),
      .cntlr_rd_data(cntlr_rd_data), .cntlr_rd_valid(cntlr_rd_valid)
`endif
   );

   // Reference model: ICCM image, queue of delivered words, one pending read, fetch pointer.
   logic [DW-1:0] m_mem [0:(1<<AW)-1];
   pq_entry_t     m_q[$];
   pq_entry_t     m_pend[$];
   logic [AW-1:0] m_fpc;
   bit            m_rd_exp;
   logic [DW-1:0] m_rd_data;
   int            n_vec = 0;
   int            n_err = 0;

   task automatic model_reset();
      m_q.delete();
      m_pend.delete();
      m_fpc     = '0;
      m_rd_exp  = 1'b0;
      m_rd_data = '0;
   endtask

   // Advance model by one cycle using the inputs currently driven, then move to the next negedge.
   task automatic tick();
      bit        pop, flush;
      int        occ;
      pq_entry_t e;
      pop   = (m_q.size() != 0) && if_ready;
      flush = (pc_sel != PC_SEQ) || cntlr_wr;
      occ   = m_q.size() + m_pend.size() - int'(pop);
      m_rd_exp = cntlr_rd;
      if (cntlr_rd) m_rd_data = m_mem[cntlr_raddr];
      if (flush) begin
         m_q.delete();
         m_pend.delete();
         if (pc_sel == PC_IMM)      m_fpc = imm_addr;
         else if (pc_sel == PC_ALU) m_fpc = alu_addr;
         else if (pc_sel == PC_RST) m_fpc = '0;
      end else begin
         if (pop) void'(m_q.pop_front());
         if (m_pend.size() != 0) m_q.push_back(m_pend.pop_front());
         if (fetch_en && !cntlr_rd && occ < PFD) begin
            e.pc    = m_fpc;
            e.instr = m_mem[m_fpc];
            m_pend.push_back(e);
            m_fpc = m_fpc + 1'b1;
         end
      end
      if (cntlr_wr) m_mem[cntlr_waddr] = cntlr_wr_data;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load_mem();
      fetch_en = 1'b0;
      for (int i = 0; i < (1 << AW); i++) begin
         cntlr_wr = 1'b1; cntlr_waddr = AW'(i); cntlr_wr_data = DW'(i);
         tick();
      end
      cntlr_wr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; fetch_en = 1'b0; if_ready = 1'b0; pc_sel = PC_SEQ;
      cntlr_wr = 1'b0; cntlr_rd = 1'b0;
      #1;
      n_vec++;
      if (if_valid !== 1'b0 || if_pc !== '0 || if_instr !== '0) begin
         n_err++;
         $display("FAIL reset_values: got v=%b pc=%h instr=%h want v=0 pc=0 instr=0", if_valid, if_pc, if_instr);
      end
`ifdef IFETCH_CNTLR_RD_EN
      n_vec++;
      if (cntlr_rd_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_rd_valid: got %b want 0", cntlr_rd_valid);
      end
`endif
      model_reset();
      @(negedge clk);
   endtask

   task automatic test_stream();
      rst_n = 1'b1; fetch_en = 1'b1; if_ready = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         n_vec++;
         if (k == 1) begin
            if (if_valid !== 1'b0) begin
               n_err++; $display("FAIL stream_latency: edge1 got v=%b want 0", if_valid);
            end
         end else if (if_valid !== 1'b1 || if_pc !== AW'(k-2) || if_instr !== DW'(k-2)) begin
            n_err++;
            $display("FAIL stream_seq: edge%0d got v=%b pc=%h instr=%h want pc=%h", k, if_valid, if_pc, if_instr, k-2);
         end
         n_vec++;
         if (if_valid !== (m_q.size() != 0)) begin
            n_err++; $display("FAIL stream_model_valid: got %b want %b", if_valid, m_q.size() != 0);
         end else if (if_valid && (if_pc !== m_q[0].pc || if_instr !== m_q[0].instr)) begin
            n_err++;
            $display("FAIL stream_model_head: got pc=%h instr=%h want pc=%h instr=%h", if_pc, if_instr, m_q[0].pc, m_q[0].instr);
         end
      end
   endtask

   task automatic test_stall();
      logic [AW-1:0] held;
      held = m_q[0].pc;
      if_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         n_vec++;
         if (if_valid !== 1'b1 || if_pc !== held || if_instr !== DW'(held)) begin
            n_err++; $display("FAIL stall_hold: cyc%0d got v=%b pc=%h want pc=%h", k, if_valid, if_pc, held);
         end
      end
      if_ready = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         tick();
         n_vec++;
         if (if_valid !== 1'b1 || if_pc !== AW'(held + AW'(j))) begin
            n_err++; $display("FAIL stall_drain: step%0d got v=%b pc=%h want pc=%h", j, if_valid, if_pc, held + AW'(j));
         end
         n_vec++;
         if (if_valid !== (m_q.size() != 0)) begin
            n_err++; $display("FAIL stall_model_valid: got %b want %b", if_valid, m_q.size() != 0);
         end else if (if_valid && (if_pc !== m_q[0].pc || if_instr !== m_q[0].instr)) begin
            n_err++; $display("FAIL stall_model_head: got pc=%h want pc=%h", if_pc, m_q[0].pc);
         end
      end
   endtask

   task automatic test_redirect();
      logic [AW-1:0] tgt;
      for (int t = 0; t < 2; t++) begin
         tgt = (t == 0) ? AW'(11'h100) : AW'(11'h040);
         if_ready = (t != 0);
         repeat ((t == 0) ? 6 : 3) tick();
         for (int k = 0; k < 6; k++) begin
            if (k == 0) begin
               pc_sel = (t == 0) ? PC_IMM : PC_ALU;
               imm_addr = tgt; alu_addr = tgt; if_ready = 1'b1;
            end else pc_sel = PC_SEQ;
            tick();
            n_vec++;
            if (k < 2) begin
               if (if_valid !== 1'b0) begin
                  n_err++; $display("FAIL redirect_flush%0d: k=%0d got v=%b want 0", t, k, if_valid);
               end
            end else if (if_valid !== 1'b1 || if_pc !== AW'(tgt + AW'(k-2)) || if_instr !== DW'(tgt + AW'(k-2))) begin
               n_err++;
               $display("FAIL redirect_target%0d: k=%0d got v=%b pc=%h want pc=%h", t, k, if_valid, if_pc, tgt + AW'(k-2));
            end
            n_vec++;
            if (if_valid !== (m_q.size() != 0)) begin
               n_err++; $display("FAIL redirect_model_valid: got %b want %b", if_valid, m_q.size() != 0);
            end else if (if_valid && (if_pc !== m_q[0].pc || if_instr !== m_q[0].instr)) begin
               n_err++; $display("FAIL redirect_model_head: got pc=%h want pc=%h", if_pc, m_q[0].pc);
            end
         end
      end
   endtask

   task automatic test_wrap();
      logic [AW-1:0] exp_pc;
      if_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (k == 0) begin pc_sel = PC_ALU; alu_addr = AW'(11'h7FE); end
         else pc_sel = PC_SEQ;
         tick();
         if (k >= 2) begin
            exp_pc = AW'(11'h7FE) + AW'(k-2);
            n_vec++;
            if (if_valid !== 1'b1 || if_pc !== exp_pc || if_instr !== DW'(exp_pc)) begin
               n_err++; $display("FAIL wrap_seq: k=%0d got v=%b pc=%h want pc=%h", k, if_valid, if_pc, exp_pc);
            end
         end
      end
   endtask

   task automatic test_cntlr_wr();
      bit seen;
      seen = 1'b0;
      if_ready = 1'b1;
      repeat (3) tick();
      cntlr_wr = 1'b1; cntlr_waddr = AW'(5); cntlr_wr_data = 32'hDEADBEEF;
      tick();
      cntlr_wr = 1'b0;
      n_vec++;
      if (if_valid !== 1'b0) begin
         n_err++; $display("FAIL wr_flush: got v=%b want 0", if_valid);
      end
      for (int k = 0; k < 24; k++) begin
         if (k == 4) begin pc_sel = PC_IMM; imm_addr = AW'(3); end
         else pc_sel = PC_SEQ;
         tick();
         n_vec++;
         if (if_valid !== (m_q.size() != 0)) begin
            n_err++; $display("FAIL wr_model_valid: got %b want %b", if_valid, m_q.size() != 0);
         end else if (if_valid && (if_pc !== m_q[0].pc || if_instr !== m_q[0].instr)) begin
            n_err++; $display("FAIL wr_model_head: got pc=%h instr=%h want pc=%h instr=%h", if_pc, if_instr, m_q[0].pc, m_q[0].instr);
         end
         if (k > 4 && if_valid === 1'b1 && if_pc === AW'(5) && !seen) begin
            seen = 1'b1;
            n_vec++;
            if (if_instr !== 32'hDEADBEEF) begin
               n_err++; $display("FAIL wr_refetch: got instr=%h want deadbeef", if_instr);
            end
         end
      end
      n_vec++;
      if (!seen) begin
         n_err++; $display("FAIL wr_refetch_timeout: address 5 not fetched within 24 cycles, want it fetched");
      end
   endtask

`ifdef IFETCH_CNTLR_RD_EN
   task automatic test_cntlr_rd();
      if_ready = 1'b1;
      repeat (4) tick();
      cntlr_rd = 1'b1; cntlr_raddr = AW'(5);
      tick();
      cntlr_rd = 1'b0;
      n_vec++;
      if (cntlr_rd_valid !== 1'b1 || cntlr_rd_data !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL rd_data: got v=%b data=%h want v=1 data=deadbeef", cntlr_rd_valid, cntlr_rd_data);
      end
      for (int k = 0; k < 6; k++) begin
         n_vec++;
         if (if_valid !== (m_q.size() != 0)) begin
            n_err++; $display("FAIL rd_model_valid: got %b want %b", if_valid, m_q.size() != 0);
         end else if (if_valid && (if_pc !== m_q[0].pc || if_instr !== m_q[0].instr)) begin
            n_err++; $display("FAIL rd_model_head: got pc=%h want pc=%h", if_pc, m_q[0].pc);
         end
         tick();
         if (k == 0) begin
            n_vec++;
            if (cntlr_rd_valid !== 1'b0) begin
               n_err++; $display("FAIL rd_pulse: got v=%b want 0", cntlr_rd_valid);
            end
         end
      end
   endtask
`endif

   task automatic test_random();
      int r;
      for (int k = 0; k < 600; k++) begin
         r = $urandom_range(0, 99);
         pc_sel = (r < 5) ? 2'($urandom_range(1, 3)) : PC_SEQ;
         imm_addr = AW'($urandom); alu_addr = AW'($urandom);
         cntlr_wr = ($urandom_range(0, 99) < 3);
         cntlr_waddr = AW'($urandom); cntlr_wr_data = $urandom;
`ifdef IFETCH_CNTLR_RD_EN
         cntlr_rd = !cntlr_wr && ($urandom_range(0, 99) < 5);
         cntlr_raddr = AW'($urandom);
`endif
         fetch_en = ($urandom_range(0, 99) < 85);
         if_ready = ($urandom_range(0, 99) < 70);
         tick();
         n_vec++;
         if (if_valid !== (m_q.size() != 0)) begin
            n_err++; $display("FAIL random_valid: cyc%0d got %b want %b", k, if_valid, m_q.size() != 0);
         end else if (if_valid && (if_pc !== m_q[0].pc || if_instr !== m_q[0].instr)) begin
            n_err++;
            $display("FAIL random_head: cyc%0d got pc=%h instr=%h want pc=%h instr=%h", k, if_pc, if_instr, m_q[0].pc, m_q[0].instr);
         end
`ifdef IFETCH_CNTLR_RD_EN
         n_vec++;
         if (cntlr_rd_valid !== m_rd_exp || (m_rd_exp && cntlr_rd_data !== m_rd_data)) begin
            n_err++;
            $display("FAIL random_rd: cyc%0d got v=%b data=%h want v=%b data=%h", k, cntlr_rd_valid, cntlr_rd_data, m_rd_exp, m_rd_data);
         end
`endif
      end
      pc_sel = PC_SEQ; cntlr_wr = 1'b0; cntlr_rd = 1'b0; fetch_en = 1'b1; if_ready = 1'b1;
   endtask

   task automatic test_mid_reset();
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (if_valid !== 1'b0 || if_pc !== '0 || if_instr !== '0) begin
         n_err++; $display("FAIL midreset_values: got v=%b pc=%h instr=%h want 0/0/0", if_valid, if_pc, if_instr);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         n_vec++;
         if (k == 2 && (if_valid !== 1'b1 || if_pc !== '0 || if_instr !== m_mem[0])) begin
            n_err++; $display("FAIL midreset_restart: got v=%b pc=%h instr=%h want pc=0 instr=%h", if_valid, if_pc, if_instr, m_mem[0]);
         end
         if (if_valid !== (m_q.size() != 0)) begin
            n_err++; $display("FAIL midreset_model_valid: got %b want %b", if_valid, m_q.size() != 0);
         end else if (if_valid && (if_pc !== m_q[0].pc || if_instr !== m_q[0].instr)) begin
            n_err++; $display("FAIL midreset_model_head: got pc=%h want pc=%h", if_pc, m_q[0].pc);
         end
      end
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      load_mem();
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_wrap();
      test_cntlr_wr();
`ifdef IFETCH_CNTLR_RD_EN
      test_cntlr_rd();
`endif
      test_random();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, want normal completion");
      $fatal(1, "watchdog");
   end

endmodule
